fetch_pc_stage: RTL

FETCH_PC_STAGE -- requirements
Module: fetch_pc_stage

---
 rtl/fetch_pc_stage_pkg.sv | 16 +
 rtl/pc_next_mux.sv | 36 +++
 rtl/fetch_pc_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// Shared definitions for the fetch PC stage: FSM encoding and datapath constants.
package fetch_pc_stage_pkg;

  // Fetch runs until it sees the halt word; only reset leaves StHalt.
  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

  // Sequential fetch stride in bytes.
  localparam int unsigned PcIncr = 4;

  // Instruction word (and pc4 value) loaded into IF/ID on a flush; doubles as NOP.
  localparam int unsigned FlushWord = 0;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage: branch > jump > stall hold > sequential.
// Purely combinational; the PC register itself lives in fetch_pc_stage.
module pc_next_mux
  import fetch_pc_stage_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic [NBITS-1:0] i_pc,
  input  logic             i_pcSrc,
  input  logic [NBITS-1:0] i_branch_addr,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_addr,
  input  logic             i_stall,
  output logic [NBITS-1:0] o_pc_next,
  output logic [NBITS-1:0] o_pc_plus4,
  output logic             o_redirect
);

  // Clears the two byte-offset bits so every target is word aligned.
  localparam logic [NBITS-1:0] AlignMask = {{(NBITS-2){1'b1}}, 2'b00};

  // Priority select of the next fetch address; PC+4 wraps naturally modulo 2^NBITS.
  always_comb begin
    o_pc_plus4 = i_pc + NBITS'(PcIncr);
    o_redirect = i_pcSrc | i_jump;
    o_pc_next  = o_pc_plus4;
    if (i_pcSrc) begin
      o_pc_next = i_branch_addr & AlignMask;
    end else if (i_jump) begin
      o_pc_next = i_jump_addr & AlignMask;
    end else if (i_stall) begin
      o_pc_next = i_pc;
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT control.
// Optional build macro FETCH_STEP_EN adds i_step, letting the debug unit single-step
// fetch while i_enable is low.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter int unsigned      NBITS     = 32,
  parameter logic [NBITS-1:0] RESET_PC  = '0,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
`ifdef FETCH_STEP_EN
  input  logic             i_step,
`endif
  input  logic             i_stall,
  input  logic             i_pcSrc,
  input  logic [NBITS-1:0] i_branch_addr,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_addr,
  input  logic [NBITS-1:0] i_instr,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_if_id_pc4,
  output logic [NBITS-1:0] o_if_id_instr,
  output logic             o_if_id_valid,
  output logic             o_halted
);

  localparam logic [NBITS-1:0] FlushVal = NBITS'(FlushWord);

  fetch_state_e     state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] pc4_q, pc4_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;

  logic [NBITS-1:0] pc_next;
  logic [NBITS-1:0] pc_plus4;
  logic             redirect;
  logic             run_gate;
  logic             advance;

  pc_next_mux #(
    .NBITS (NBITS)
  ) u_pc_next_mux (
    .i_pc          (pc_q),
    .i_pcSrc       (i_pcSrc),
    .i_branch_addr (i_branch_addr),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .i_stall       (i_stall),
    .o_pc_next     (pc_next),
    .o_pc_plus4    (pc_plus4),
    .o_redirect    (redirect)
  );

  // Run gate: debug enable, or a single-step pulse when stepping is built in.
`ifdef FETCH_STEP_EN
  assign run_gate = i_enable | i_step;
`else
  assign run_gate = i_enable;
`endif

  assign advance = run_gate && (state_q == StRun);

  // Next-state for PC, IF/ID and fetch FSM; everything holds unless this is an advance cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;

    if (advance) begin
      if (redirect) begin
        // Redirect wins over stall: the wrong-path instruction becomes a bubble.
        pc_d    = pc_next;
        pc4_d   = FlushVal;
        instr_d = FlushVal;
        valid_d = 1'b0;
      end else if (i_stall) begin
        // Load-use stall: PC and IF/ID hold as they are.
        pc_d = pc_q;
      end else begin
        pc4_d   = pc_plus4;
        instr_d = i_instr;
        valid_d = 1'b1;
        if (i_instr == HALT_WORD) begin
          // Halt word still enters IF/ID, but fetch parks on its address.
          state_d = StHalt;
          pc_d    = pc_q;
        end else begin
          pc_d = pc_next;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      pc4_q   <= FlushVal;
      instr_q <= FlushVal;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_pc          = pc_q;
    o_if_id_pc4   = pc4_q;
    o_if_id_instr = instr_q;
    o_if_id_valid = valid_q;
    o_halted      = (state_q == StHalt);
  end

endmodule
